full_adder_3_bit_to_4_bit: RTL and testbench

- Unsigned ripple-carry adder: two WIDTH-bit operands give a (WIDTH+1)-bit sum, with no carry-in.
- Built from WIDTH chained 1-bit full-adder cells. The carry out of the last cell is the sum MSB.
- Used as a neighbour-count building block in the Conway datapath.
- Provides a purely combinational sum and a one-cycle registered copy with a valid flag for pipelined consumers.

---
 rtl/full_adder_3_bit_to_4_bit.sv | 42 ++++
 tb/tb_full_adder_3_bit_to_4_bit.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/full_adder_3_bit_to_4_bit.sv
// Unsigned ripple-carry adder built from chained 1-bit full-adder cells, with a
// combinational sum and a one-cycle registered copy qualified by out_valid.
module full_adder_3_bit_to_4_bit #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic [WIDTH:0]   sum,
  output logic [WIDTH:0]   sum_q,
  output logic             out_valid
);

  // Ripple chain: each iteration is one full-adder cell; carry flows LSB to MSB.
  always_comb begin
    logic carry;
    carry = 1'b0;
    sum   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      // NOTE: blocking assignments here make carry a true ripple, each cell
      // seeing the carry produced by the cell before it in the same evaluation.
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    sum[WIDTH] = carry;
  end

  // out_valid follows in_valid by one edge; sum_q only loads on a valid beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q     <= '0;
      out_valid <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      out_valid <= in_valid;
      if (in_valid) sum_q <= sum;
    end
  end

endmodule

// File: tb/tb_full_adder_3_bit_to_4_bit.sv
// Self-checking bench: exhaustive combinational sweep, then registered path
// with a scoreboard queue of expected sum_q values.
module tb_full_adder_3_bit_to_4_bit;

  localparam int WIDTH = 3;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             in_valid;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   sum_q;
  logic             out_valid;

  logic             clk_run = 1'b0;
  int               vectors = 0;
  int               miscompares = 0;
  logic [WIDTH:0]   exp_q[$];
  logic [WIDTH:0]   last_q;

  full_adder_3_bit_to_4_bit #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
    .sum       (sum),
    .sum_q     (sum_q),
    .out_valid (out_valid)
  );

  // Clock stays undriven (X) until clk_run is raised.
  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one beat, wait for the capturing edge, then compare 1 unit later.
  task automatic beat(input int ia, input int ib, input logic iv);
    logic [WIDTH:0] e;
    a        = ia[WIDTH-1:0];
    b        = ib[WIDTH-1:0];
    in_valid = iv;
    if (iv) exp_q.push_back(4'(ia + ib));
    @(posedge clk);
    #1;
    check("out_valid", {31'd0, out_valid}, {31'd0, iv});
    if (iv) begin
      if (exp_q.size() == 0) begin
        check("sb_empty", 32'd1, 32'd0);
      end else begin
        e      = exp_q.pop_front();
        last_q = e;
        check("sum_q", {28'd0, sum_q}, {28'd0, e});
      end
    end else begin
      check("sum_q_hold", {28'd0, sum_q}, {28'd0, last_q});
    end
  endtask

  initial begin
    in_valid = 1'b0;
    last_q   = '0;

    // Combinational sweep with clk and rst_n undriven.
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        a = 3'(i);
        b = 3'(j);
        #1;
        check("comb", {28'd0, sum}, 32'(i + j));
      end
    end
    a = 3'b111; b = 3'b001; #1; check("ripple_all", {28'd0, sum}, 32'b1000);
    a = 3'b100; b = 3'b100; #1; check("ripple_msb", {28'd0, sum}, 32'b1000);
    a = 3'd6;   b = 3'd6;   #1; check("spot_6_6",   {28'd0, sum}, 32'b1100);

    // Start the clock with reset asserted.
    rst_n   = 1'b0;
    clk     = 1'b0;
    clk_run = 1'b1;
    #1;
    check("rst_sum_q", {28'd0, sum_q}, 32'd0);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    check("rst_hold_q", {28'd0, sum_q}, 32'd0);
    check("rst_hold_v", {31'd0, out_valid}, 32'd0);
    in_valid = 1'b0;
    #2 rst_n = 1'b1;

    // First edge after release with in_valid low.
    beat(2, 2, 1'b0);

    // Registered latency and hold.
    beat(5, 6, 1'b1);
    beat(1, 1, 1'b0);

    // Async reset between edges, no clock edge needed.
    #2;
    rst_n = 1'b0;
    #1;
    check("async_q", {28'd0, sum_q}, 32'd0);
    check("async_v", {31'd0, out_valid}, 32'd0);
    a = 3'd7; b = 3'd5; #1;
    check("comb_in_rst", {28'd0, sum}, 32'd12);
    exp_q.delete();
    last_q = '0;
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Back-to-back stream, then drain.
    beat(1, 1, 1'b1);
    beat(2, 3, 1'b1);
    beat(7, 7, 1'b1);
    beat(0, 0, 1'b1);
    beat(3, 4, 1'b0);
    check("sb_drained", exp_q.size(), 32'd0);

    // Randomised beats with mixed in_valid.
    for (int k = 0; k < 20; k++) begin
      beat(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
